// File: rtl/alu_pkg.sv
// Shared encodings and FSM state type for the execute-stage ALU.
// ALU_DIV_EN selects whether DIVU/REMU get a datapath (see alu_seq_unit).
package alu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD   = 4'd0;
  localparam logic [OPW-1:0] OP_SUB   = 4'd1;
  localparam logic [OPW-1:0] OP_AND   = 4'd2;
  localparam logic [OPW-1:0] OP_OR    = 4'd3;
  localparam logic [OPW-1:0] OP_XOR   = 4'd4;
  localparam logic [OPW-1:0] OP_NOR   = 4'd5;
  localparam logic [OPW-1:0] OP_SLT   = 4'd6;
  localparam logic [OPW-1:0] OP_LUI   = 4'd7;
  localparam logic [OPW-1:0] OP_SLTU  = 4'd8;
  localparam logic [OPW-1:0] OP_MUL   = 4'd9;
  localparam logic [OPW-1:0] OP_MULHU = 4'd10;
  localparam logic [OPW-1:0] OP_DIVU  = 4'd11;
  localparam logic [OPW-1:0] OP_REMU  = 4'd12;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// WIDTH-cycle iterative engine: shift-add multiply and (with ALU_DIV_EN)
// restoring divide. Result in {hi, lo}: product, or remainder/quotient.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH:0]   sum;
  logic             start_ok;

`ifdef ALU_DIV_EN
  logic             mode_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  assign start_ok = start;
`else
  assign start_ok = start && (mode == MODE_MUL);
`endif

  assign done = run && (cnt == CW'(WIDTH - 1));

  // One iteration: multiply adds then shifts right; divide shifts left then trial-subtracts.
  always_comb begin
    sum  = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    if (mode_q == MODE_DIV) begin
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
`ifdef ALU_DIV_EN
      mode_q <= MODE_MUL;
`endif
    end else if (flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start_ok) begin
      run <= 1'b1;
      cnt <= '0;
      m   <= b;
      hi  <= '0;
      lo  <= a;
`ifdef ALU_DIV_EN
      mode_q <= mode;
`endif
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= done ? '0 : cnt + CW'(1);
      run <= !done;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops plus iterative
// MUL/MULHU and, when ALU_DIV_EN is defined, DIVU/REMU.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             z,
  output logic             dz
);
  import alu_pkg::*;

  state_t           state, state_n;
  logic [OPW-1:0]   op_q;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             start;
  logic             mode;
  logic             eng_done;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] iter_res;
  logic             iter_dz;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign is_mul   = (aluop == OP_MUL) || (aluop == OP_MULHU);

`ifdef ALU_DIV_EN
  logic bz_q;
  assign is_div  = (aluop == OP_DIVU) || (aluop == OP_REMU);
  assign iter_dz = ((op_q == OP_DIVU) || (op_q == OP_REMU)) && bz_q;
`else
  assign is_div  = 1'b0;
  assign iter_dz = 1'b0;
`endif

  // Single-cycle results; unused encodings (and divide when disabled) give zero.
  always_comb begin
    single_res = '0;
    case (aluop)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_XOR:  single_res = a ^ b;
      OP_NOR:  single_res = ~(a | b);
      OP_SLT:  single_res = WIDTH'($signed(a) < $signed(b));
      OP_LUI:  single_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLTU: single_res = WIDTH'(a < b);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    iter_res = eng_lo;
    case (op_q)
      OP_MULHU: iter_res = eng_hi;
      OP_REMU:  iter_res = eng_hi;
      default:  iter_res = eng_lo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    mode    = MODE_MUL;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_n = MUL;
          start   = 1'b1;
        end else if (accept && is_div) begin
          state_n = DIV;
          start   = 1'b1;
          mode    = MODE_DIV;
        end
      end
      MUL, DIV: if (eng_done) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Output registers: flush drops the pending result but keeps o/z/dz.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o         <= '0;
      z         <= 1'b1;
      dz        <= 1'b0;
      out_valid <= 1'b0;
      op_q      <= '0;
`ifdef ALU_DIV_EN
      bz_q      <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        op_q <= aluop;
`ifdef ALU_DIV_EN
        bz_q <= (b == '0);
`endif
      end
      if (accept && !is_mul && !is_div) begin
        o         <= single_res;
        z         <= (single_res == '0);
        dz        <= 1'b0;
        out_valid <= 1'b1;
      end
      if (state == DONE) begin
        o         <= iter_res;
        z         <= (iter_res == '0);
        dz        <= iter_dz;
        out_valid <= 1'b1;
      end
    end
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .done  (eng_done),
    .hi    (eng_hi),
    .lo    (eng_lo)
  );

endmodule
